// File: rtl/util_gmii_merge.sv
// Merges two GMII transmit streams onto one output. Arbitration happens only at frame starts.
// An inter-frame gap is enforced. Frames that cannot be forwarded are dropped whole and counted.
module util_gmii_merge #(
    parameter int IFG_CYCLES    = 12,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               s_gmii_a_txd,
    input  logic                     s_gmii_a_tx_er,
    input  logic                     s_gmii_a_tx_en,
    input  logic [7:0]               s_gmii_b_txd,
    input  logic                     s_gmii_b_tx_er,
    input  logic                     s_gmii_b_tx_en,
    output logic [7:0]               m_gmii_txd,
    output logic                     m_gmii_tx_er,
    output logic                     m_gmii_tx_en,
    output logic [1:0]               active,
    output logic [COUNTER_WIDTH-1:0] drop_count_a,
    output logic [COUNTER_WIDTH-1:0] drop_count_b,
    input  logic                     clear_counters
);

    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IFG_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FWD_A = 2'd1,
        ST_FWD_B = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t           state_r, state_next_s;
    logic [GAP_W-1:0] gap_cnt_r, gap_next_s;
    logic             prev_en_a_r, prev_en_b_r;
    logic             last_grant_r;
    logic             start_a_s, start_b_s, arb_open_s;
    logic             grant_a_s, grant_b_s;
    logic             drop_a_s, drop_b_s;
    logic [7:0]       txd_next_s;
    logic             tx_er_next_s, tx_en_next_s;
    logic [1:0]       active_next_s;

    function automatic logic [COUNTER_WIDTH-1:0] next_count(
        input logic [COUNTER_WIDTH-1:0] cnt,
        input logic                     inc,
        input logic                     clr
    );
        logic [COUNTER_WIDTH-1:0] res;
        if (clr) begin
            res = {COUNTER_WIDTH{1'b0}};
        end else if (inc && (cnt != {COUNTER_WIDTH{1'b1}})) begin
            res = cnt + COUNTER_WIDTH'(1);
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    assign start_a_s = s_gmii_a_tx_en & ~prev_en_a_r;
    assign start_b_s = s_gmii_b_tx_en & ~prev_en_b_r;
    // The last gap cycle already accepts a new start so the output gap is exactly IFG_CYCLES.
    assign arb_open_s = (state_r == ST_IDLE) || ((state_r == ST_GAP) && (gap_cnt_r == {GAP_W{1'b0}}));
    // Anything that starts without being granted is lost for its whole frame.
    assign drop_a_s = start_a_s & ~grant_a_s;
    assign drop_b_s = start_b_s & ~grant_b_s;

    // Round-robin grant among starts seen while arbitration is open.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (arb_open_s) begin
            if (start_a_s && start_b_s) begin
                grant_a_s = ~last_grant_r;
                grant_b_s = last_grant_r;
            end else begin
                grant_a_s = start_a_s;
                grant_b_s = start_b_s;
            end
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    // Next-state and gap counter logic.
    always_comb begin
        state_next_s = state_r;
        gap_next_s   = gap_cnt_r;
        case (state_r)
            ST_IDLE, ST_GAP: begin
                if (grant_a_s) begin
                    state_next_s = ST_FWD_A;
                end else if (grant_b_s) begin
                    state_next_s = ST_FWD_B;
                end else if ((state_r == ST_GAP) && (gap_cnt_r != {GAP_W{1'b0}})) begin
                    state_next_s = ST_GAP;
                    gap_next_s   = gap_cnt_r - GAP_W'(1);
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FWD_A: begin
                if (s_gmii_a_tx_en) begin
                    state_next_s = ST_FWD_A;
                end else begin
                    state_next_s = ST_GAP;
                    gap_next_s   = GAP_LOAD;
                end
            end
            ST_FWD_B: begin
                if (s_gmii_b_tx_en) begin
                    state_next_s = ST_FWD_B;
                end else begin
                    state_next_s = ST_GAP;
                    gap_next_s   = GAP_LOAD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                gap_next_s   = {GAP_W{1'b0}};
            end
        endcase
    end

    // Output values for the coming cycle, selected by the state being entered.
    always_comb begin
        txd_next_s    = 8'h00;
        tx_er_next_s  = 1'b0;
        tx_en_next_s  = 1'b0;
        active_next_s = 2'b00;
        case (state_next_s)
            ST_FWD_A: begin
                txd_next_s    = s_gmii_a_txd;
                tx_er_next_s  = s_gmii_a_tx_er;
                tx_en_next_s  = 1'b1;
                active_next_s = 2'b01;
            end
            ST_FWD_B: begin
                txd_next_s    = s_gmii_b_txd;
                tx_er_next_s  = s_gmii_b_tx_er;
                tx_en_next_s  = 1'b1;
                active_next_s = 2'b10;
            end
            default: begin
                txd_next_s    = 8'h00;
                tx_er_next_s  = 1'b0;
                tx_en_next_s  = 1'b0;
                active_next_s = 2'b00;
            end
        endcase
    end

    // State, gap counter, edge detectors and grant history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            gap_cnt_r    <= {GAP_W{1'b0}};
            prev_en_a_r  <= 1'b1;
            prev_en_b_r  <= 1'b1;
            last_grant_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            gap_cnt_r   <= gap_next_s;
            prev_en_a_r <= s_gmii_a_tx_en;
            prev_en_b_r <= s_gmii_b_tx_en;
            if (grant_a_s) begin
                last_grant_r <= 1'b1;
            end else if (grant_b_s) begin
                last_grant_r <= 1'b0;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    // Registered GMII output and activity flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_gmii_txd   <= 8'h00;
            m_gmii_tx_er <= 1'b0;
            m_gmii_tx_en <= 1'b0;
            active       <= 2'b00;
        end else begin
            m_gmii_txd   <= txd_next_s;
            m_gmii_tx_er <= tx_er_next_s;
            m_gmii_tx_en <= tx_en_next_s;
            active       <= active_next_s;
        end
    end

    // Saturating drop counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count_a <= {COUNTER_WIDTH{1'b0}};
            drop_count_b <= {COUNTER_WIDTH{1'b0}};
        end else begin
            drop_count_a <= next_count(drop_count_a, drop_a_s, clear_counters);
            drop_count_b <= next_count(drop_count_b, drop_b_s, clear_counters);
        end
    end

endmodule

// File: tb/tb_util_gmii_merge.sv
// Directed bench for util_gmii_merge (IFG_CYCLES=12, COUNTER_WIDTH=2 to reach saturation quickly).
module tb_util_gmii_merge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a_txd = 8'h00, b_txd = 8'h00;
    logic       a_er = 1'b0, b_er = 1'b0, a_en = 1'b0, b_en = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] m_txd;
    logic       m_er, m_en;
    logic [1:0] active;
    logic [1:0] dca, dcb;
    int         checks = 0;
    int         failures = 0;

    util_gmii_merge #(.IFG_CYCLES(12), .COUNTER_WIDTH(2)) dut (
        .clk(clk), .rst(rst),
        .s_gmii_a_txd(a_txd), .s_gmii_a_tx_er(a_er), .s_gmii_a_tx_en(a_en),
        .s_gmii_b_txd(b_txd), .s_gmii_b_tx_er(b_er), .s_gmii_b_tx_en(b_en),
        .m_gmii_txd(m_txd), .m_gmii_tx_er(m_er), .m_gmii_tx_en(m_en),
        .active(active), .drop_count_a(dca), .drop_count_b(dcb),
        .clear_counters(clear)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] out_word();
        return {20'd0, active, m_en, m_er, m_txd};
    endfunction

    function automatic logic [31:0] exp_word(input logic [1:0] act, input logic en, input logic [7:0] d);
        return {20'd0, act, en, 1'b0, d};
    endfunction

    function automatic logic [31:0] counters();
        return {28'd0, dca, dcb};
    endfunction

    task automatic idle_inputs();
        a_en = 1'b0; a_txd = 8'h00; b_en = 1'b0; b_txd = 8'h00; clear = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        idle_inputs();
        tick();
        tick();
        check("reset_out", out_word(), 32'h0);
        check("reset_cnt", counters(), 32'h0);
        rst = 1'b0;
        tick();
        check("post_reset_out", out_word(), 32'h0);

        // Single 64-byte frame on A
        for (int i = 0; i < 64; i++) begin
            a_en = 1'b1; a_txd = 8'(i);
            tick();
            check("single_a", out_word(), exp_word(2'b01, 1'b1, 8'(i)));
        end
        idle_inputs();
        tick();
        check("single_a_end", out_word(), 32'h0);
        check("single_a_cnt", counters(), 32'h0);

        // Simultaneous starts: A wins first, B second
        do_reset();
        for (int i = 0; i < 8; i++) begin
            a_en = 1'b1; a_txd = 8'hA0 + 8'(i); b_en = 1'b1; b_txd = 8'hB0 + 8'(i);
            tick();
            check("simul1_out", out_word(), exp_word(2'b01, 1'b1, 8'hA0 + 8'(i)));
        end
        check("simul1_cnt", counters(), {28'd0, 2'd0, 2'd1});
        idle_inputs();
        repeat (20) tick();
        check("simul_gap_out", out_word(), 32'h0);
        for (int i = 0; i < 8; i++) begin
            a_en = 1'b1; a_txd = 8'hA0 + 8'(i); b_en = 1'b1; b_txd = 8'hB0 + 8'(i);
            tick();
            check("simul2_out", out_word(), exp_word(2'b10, 1'b1, 8'hB0 + 8'(i)));
        end
        check("simul2_cnt", counters(), {28'd0, 2'd1, 2'd1});
        idle_inputs();
        repeat (20) tick();

        // B starts 10 cycles into a 100-byte A frame, later B frame is forwarded
        do_reset();
        for (int i = 0; i < 100; i++) begin
            a_en = 1'b1; a_txd = 8'(i);
            b_en = (i >= 10 && i < 40); b_txd = 8'hC0;
            tick();
            check("overlap_out", out_word(), exp_word(2'b01, 1'b1, 8'(i)));
        end
        check("overlap_cnt", counters(), {28'd0, 2'd0, 2'd1});
        idle_inputs();
        repeat (13) tick();
        for (int i = 0; i < 10; i++) begin
            b_en = 1'b1; b_txd = 8'h50 + 8'(i);
            tick();
            check("late_b_out", out_word(), exp_word(2'b10, 1'b1, 8'h50 + 8'(i)));
        end
        idle_inputs();
        tick();
        check("late_b_end", out_word(), 32'h0);
        check("late_b_cnt", counters(), {28'd0, 2'd0, 2'd1});
        repeat (20) tick();

        // IFG: B 5 cycles after A output ends is dropped
        do_reset();
        for (int i = 0; i < 8; i++) begin
            a_en = 1'b1; a_txd = 8'h10 + 8'(i);
            tick();
            check("ifg_a1", out_word(), exp_word(2'b01, 1'b1, 8'h10 + 8'(i)));
        end
        idle_inputs();
        repeat (5) tick();
        for (int i = 0; i < 6; i++) begin
            b_en = 1'b1; b_txd = 8'h60 + 8'(i);
            tick();
            check("ifg_drop_out", out_word(), 32'h0);
        end
        idle_inputs();
        tick();
        check("ifg_drop_cnt", counters(), {28'd0, 2'd0, 2'd1});
        repeat (30) tick();

        // IFG: 12-cycle input gap, B forwarded after exactly 12 idle output cycles
        for (int i = 0; i < 8; i++) begin
            a_en = 1'b1; a_txd = 8'h20 + 8'(i);
            tick();
            check("ifg_a2", out_word(), exp_word(2'b01, 1'b1, 8'h20 + 8'(i)));
        end
        idle_inputs();
        for (int i = 0; i < 12; i++) begin
            tick();
            check("ifg_idle", out_word(), 32'h0);
        end
        for (int i = 0; i < 6; i++) begin
            b_en = 1'b1; b_txd = 8'h70 + 8'(i);
            tick();
            check("ifg_b_fwd", out_word(), exp_word(2'b10, 1'b1, 8'h70 + 8'(i)));
        end
        idle_inputs();
        tick();
        check("ifg_b_cnt", counters(), {28'd0, 2'd0, 2'd1});
        repeat (20) tick();

        // Reset mid-frame with A held high
        do_reset();
        for (int i = 0; i < 5; i++) begin
            a_en = 1'b1; a_txd = 8'h30 + 8'(i);
            tick();
            check("rst_pre", out_word(), exp_word(2'b01, 1'b1, 8'h30 + 8'(i)));
        end
        a_txd = 8'h77;
        rst = 1'b1;
        tick();
        check("rst_mid_out", out_word(), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_release_out", out_word(), 32'h0);
        end
        idle_inputs();
        tick();
        check("rst_cnt", counters(), 32'h0);

        // Saturation (5 drops -> 3) and clear with simultaneous drop
        do_reset();
        for (int i = 0; i < 20; i++) begin
            a_en = 1'b1; a_txd = 8'h80 + 8'(i);
            b_en = ((i >= 2 && i <= 10 && (i % 2) == 0) || i == 12 || i == 14);
            b_txd = 8'hEE;
            clear = (i == 12);
            tick();
            check("sat_out", out_word(), exp_word(2'b01, 1'b1, 8'h80 + 8'(i)));
            if (i == 4)  check("sat_2", {30'd0, dcb}, 32'd2);
            if (i == 10) check("sat_5", {30'd0, dcb}, 32'd3);
            if (i == 12) check("sat_clear", {30'd0, dcb}, 32'd0);
            if (i == 14) check("sat_after_clear", {30'd0, dcb}, 32'd1);
        end
        idle_inputs();
        tick();
        check("sat_a_cnt", {30'd0, dca}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/util_gmii_merge.md
# util_gmii_merge

Merges two GMII transmit streams (A and B) onto one GMII transmit output. It is the converging counterpart of the GMII slice that splits one GMII port into separate TX and RX paths. Arbitration happens only at frame boundaries, and a minimum inter-frame gap is enforced on the output. GMII has no backpressure, so a frame that loses arbitration or starts too early is dropped whole and counted; it is never truncated or interleaved.

## Interface

- IFG_CYCLES, 12, minimum idle output cycles between forwarded frames (≥1)
- COUNTER_WIDTH, 32, width of drop counters

- clk  in  1  GMII TX clock (125 MHz); all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_gmii_a_txd  in  8  source A data
- s_gmii_a_tx_er  in  1  source A error
- s_gmii_a_tx_en  in  1  source A enable
- s_gmii_b_txd / s_gmii_b_tx_er / s_gmii_b_tx_en  in  8/1/1  source B, same meaning
- m_gmii_txd  out  8  merged data
- m_gmii_tx_er  out  1  merged error
- m_gmii_tx_en  out  1  merged enable
- active  out  2  bit0 = forwarding A, bit1 = forwarding B; never both
- drop_count_a  out  COUNTER_WIDTH  frames dropped from A
- drop_count_b  out  COUNTER_WIDTH  frames dropped from B
- clear_counters  in  1  synchronous clear of both drop counters

## Operation

- Frame start on input x: tx_en=1 in a cycle where its registered previous tx_en=0.
- On rst, the previous-enable registers are set to 1. An input frame already in progress when reset releases is therefore not a start; it is ignored and not counted.
- FSM states:
  - IDLE: outputs zero.
  - FWD_A / FWD_B: outputs are the registered copy of the granted input (txd, tx_er, tx_en).
  - GAP: outputs zero while the gap counter runs.
- IDLE transitions:
  - Start on one input only: go to FWD of that input; its first byte appears on the output next cycle.
  - Starts on both inputs in the same cycle: grant by round robin. A last_grant bit selects the winner; it resets to favour A and toggles to the other side after each grant. The loser's drop counter increments once.
- FWD_x to GAP: when input x tx_en=0, the output tx_en goes 0 the next cycle and the gap counter loads IFG_CYCLES-1.
- GAP to IDLE: after exactly IFG_CYCLES zero output cycles.
- Drops: any start detected in FWD_x (on the other input) or in GAP, including the cycle input x ends, increments that input's drop counter once. The whole frame is then ignored until its tx_en falls.
- Carrier extension (tx_en=0, tx_er=1) is not forwarded. tx_er is forwarded only during frame cycles.
- Drop counters saturate at all-ones. clear_counters has priority over a simultaneous increment; the result is 0.
- active follows the FSM state: 01 in FWD_A, 10 in FWD_B, 00 otherwise.

## Timing

- Latency input to output: exactly 1 cycle. There are no bubbles inside a forwarded frame; an output frame has the same length as its input frame.
- At least IFG_CYCLES cycles of tx_en=0 separate any two output frames. For the same source, back-to-back input frames with an input gap of ≥ IFG_CYCLES+1 are never dropped.
- active and drop counters are registered and update in the cycle after the causing input edge.
- Reset values: m_gmii_txd=0, m_gmii_tx_er=0, m_gmii_tx_en=0, active=00, drop counters 0, state IDLE, last_grant favours A.
- rst asserted mid-frame: outputs are zero in the cycle after rst is sampled. The truncated frame is not counted as a drop.

## Test plan

- Single frame on A: 64 bytes 0x00..0x3F, B idle. Required: identical bytes on m_gmii_* one cycle later, active=01 for 64 cycles, both counters 0.
- Simultaneous starts after reset: A and B both rise in the same cycle, twice, with a ≥20-cycle gap between the pairs. Required: first pair forwards A and drop_count_b=1; second pair forwards B and drop_count_a=1.
- Overlap: B starts 10 cycles into a 100-byte A frame. Required: only A is output and drop_count_b=1. A later B frame, started ≥13 cycles after A ends, is forwarded.
- IFG enforcement with IFG_CYCLES=12: B starts 5 cycles after A's output ends. Required: B dropped and drop_count_b=1. The same test with a 12-cycle input gap after the end of A forwards B, with exactly 12 idle output cycles between the frames.
- Reset mid-frame plus saturation: assert rst during an A frame with the input held high. Required: output zero and no start on release. Separately, with COUNTER_WIDTH=2, 5 drops give drop_count=3; clear_counters together with a drop gives 0.
